// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round engine: runs encrypt or decrypt on a 128-bit block, one round per consumed round key.
// Latency: accept at cycle T, result valid at T+12 when keys are never stalled (one extra cycle per stalled key).
// Backpressure: in_ready only while idle; key fetch stalls on rk_valid=0; result held on out_valid until out_ready.
//
// Ports:
//   clk, rst_n                  - single clock, synchronous active-low reset
//   in_valid/in_ready/in_decrypt/in_data - block input handshake; mode and block are latched on accept
//   rk_req/rk_idx/rk_valid/rk_data      - round-key fetch; a step is taken in each cycle with rk_req && rk_valid
//   out_valid/out_ready/out_data        - result handshake; out_data is zero outside DONE
//   busy                        - high whenever the engine is not idle

// Byte permutation of the AES state: row r rotated left by r (forward) or right by r (inverse).
// Bytes are column-major with byte 0 in bits 127:120, so byte i sits at row i%4, column i/4.
module shift_rows #(
  parameter bit INVERSE = 1'b0
) (
  input  logic [127:0] state,
  output logic [127:0] shifted
);
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int ROW = i % 4;
    localparam int COL = i / 4;
    localparam int SRC = INVERSE ? (COL + 4 - ROW) % 4 : (COL + ROW) % 4;
    assign shifted[127-8*i -: 8] = state[127-8*(ROW+4*SRC) -: 8];
  end
endmodule

module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_decrypt,
  input  logic [127:0] in_data,
  output logic         rk_req,
  output logic [3:0]   rk_idx,
  input  logic         rk_valid,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam logic [3:0] LAST = 4'(NR);

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         decrypt_q, decrypt_d;

  // ---------------------------------------------------------------- GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a126, a127;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a6   = gmul(a3, a3);
    a12  = gmul(a6, a6);
    a15  = gmul(a12, a3);
    a30  = gmul(a15, a15);
    a60  = gmul(a30, a30);
    a120 = gmul(a60, a60);
    a126 = gmul(a120, a6);
    a127 = gmul(a126, a);
    return gmul(a127, a127);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] v;
    v = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(v);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // ---------------------------------------------------------------- datapath
  // (Inv)ShiftRows is applied before (Inv)SubBytes in both directions; the two
  // commute because SubBytes is bytewise, so one byte-substitution stage serves both.
  logic [127:0] sr_fwd, sr_inv, sr_sel;
  logic [127:0] sub_out, add_key, mix_out, inv_mix_out, round_out;

  shift_rows #(.INVERSE(1'b0)) u_sr_fwd (.state(state_q), .shifted(sr_fwd));
  shift_rows #(.INVERSE(1'b1)) u_sr_inv (.state(state_q), .shifted(sr_inv));

  assign sr_sel = decrypt_q ? sr_inv : sr_fwd;

  always_comb begin
    sub_out = '0;
    for (int i = 0; i < 16; i++) begin
      sub_out[127-8*i -: 8] = decrypt_q ? inv_sbox(sr_sel[127-8*i -: 8])
                                        : sbox(sr_sel[127-8*i -: 8]);
    end
  end

  assign add_key = sub_out ^ rk_data;

  always_comb begin
    mix_out     = '0;
    inv_mix_out = '0;
    for (int c = 0; c < 4; c++) begin
      mix_out[127-32*c -: 32]     = mix_col(sub_out[127-32*c -: 32]);
      inv_mix_out[127-32*c -: 32] = inv_mix_col(add_key[127-32*c -: 32]);
    end
  end

  // Encrypt mixes before the key add; the straight inverse cipher mixes after it.
  assign round_out = decrypt_q ? inv_mix_out : (mix_out ^ rk_data);

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      rnd_q     <= '0;
      decrypt_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      decrypt_q <= decrypt_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    rnd_d     = rnd_q;
    decrypt_d = decrypt_q;
    in_ready  = 1'b0;
    rk_req    = 1'b0;
    rk_idx    = '0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b1;

    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_d   = in_data;
          decrypt_d = in_decrypt;
          rnd_d     = '0;
          fsm_d     = INIT;
        end
      end
      INIT: begin
        rk_req = 1'b1;
        rk_idx = decrypt_q ? LAST - rnd_q : rnd_q;
        if (rk_valid) begin
          state_d = state_q ^ rk_data;
          rnd_d   = rnd_q + 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        rk_req = 1'b1;
        rk_idx = decrypt_q ? LAST - rnd_q : rnd_q;
        if (rk_valid) begin
          state_d = round_out;
          rnd_d   = rnd_q + 4'd1;
          if (rnd_q == LAST - 4'd1) fsm_d = FINAL;
        end
      end
      FINAL: begin
        rk_req = 1'b1;
        rk_idx = decrypt_q ? LAST - rnd_q : rnd_q;
        if (rk_valid) begin
          state_d = add_key;
          fsm_d   = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = state_q;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_decrypt;
  logic [127:0] in_data;
  logic         rk_req, rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid, out_ready, busy;
  logic [127:0] out_data;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt), .in_data(in_data),
    .rk_req(rk_req), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_data(rk_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0]   sb [256];
  logic [7:0]   isb [256];
  logic [127:0] rk_tab [11];
  logic [127:0] junk_rk = '0;
  logic         stall_en = 1'b0;
  logic [127:0] exp_q [$];

  // Key server: garbage on the data lines whenever the key is withheld.
  assign rk_data = !rk_valid ? junk_rk : (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------ reference model
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input int k);
    logic [7:0] m2, m4, m8;
    m2 = xt(a); m4 = xt(m2); m8 = xt(m4);
    case (k)
      1:  return a;
      2:  return m2;
      3:  return m2 ^ a;
      9:  return m8 ^ a;
      11: return m8 ^ m2 ^ a;
      13: return m8 ^ m4 ^ a;
      default: return m8 ^ m4 ^ m2;  // 14
    endcase
  endfunction

  // Table built by walking the multiplicative group with generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_m(input logic [127:0] s, input bit inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv ? isb[gb(s, i)] : sb[gb(s, i)];
    return r;
  endfunction

  function automatic logic [127:0] shift_m(input logic [127:0] s, input bit inv);
    logic [127:0] r;
    logic [7:0]   row [4];
    for (int rw = 0; rw < 4; rw++) begin
      for (int c = 0; c < 4; c++) row[c] = gb(s, rw + 4*c);
      for (int c = 0; c < 4; c++) r[127-8*(rw+4*c) -: 8] = row[(c + (inv ? 4 - rw : rw)) % 4];
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_m(input logic [127:0] s, input bit inv);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   acc;
    int           cf [4];
    if (inv) cf = '{14, 11, 13, 9}; else cf = '{2, 3, 1, 1};
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = gb(s, 4*c + j);
      for (int rw = 0; rw < 4; rw++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(a[j], cf[(j - rw + 4) % 4]);
        r[127-8*(4*c+rw) -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic key_exp(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] enc_m(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_tab[0];
    for (int r = 1; r <= 10; r++) begin
      s = shift_m(sub_m(s, 1'b0), 1'b0);
      if (r < 10) s = mix_m(s, 1'b0);
      s = s ^ rk_tab[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] dec_m(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk_tab[10];
    for (int r = 9; r >= 0; r--) begin
      s = sub_m(shift_m(s, 1'b1), 1'b1) ^ rk_tab[r];
      if (r > 0) s = mix_m(s, 1'b1);
    end
    return s;
  endfunction

  // ------------------------------------------------------------ key-stall driver
  initial begin
    rk_valid = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_en) begin
        rk_valid = 1'($urandom_range(0, 1));
        junk_rk  = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        rk_valid = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ monitor
  bit         active = 0, seen_valid = 0, mode = 0;
  bit         stall_prev = 0, hold_prev = 0;
  int         acc_cyc = 0, step = 0, stalls = 0;
  logic [3:0]   idx_prev;
  logic [127:0] data_prev, exp_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      active = 0; stall_prev = 0; hold_prev = 0;
    end else begin
      chk("busy_not_ready", busy, !in_ready);
      if (!out_valid) chk("out_data_zero", out_data, '0);
      if (stall_prev) begin
        chk("stall_rk_req", rk_req, 1'b1);
        chk("stall_rk_idx", rk_idx, idx_prev);
      end
      if (hold_prev) begin
        chk("hold_out_valid", out_valid, 1'b1);
        chk("hold_out_data", out_data, data_prev);
      end
      if (out_valid) chk("done_in_ready", in_ready, 1'b0);
      if (!active) chk("rk_req_idle", rk_req, 1'b0);
      else if (rk_req) begin
        if (rk_valid) begin
          chk("rk_idx", rk_idx, mode ? 10 - step : step);
          step++;
        end else stalls++;
      end
      stall_prev = rk_req && !rk_valid;
      idx_prev   = rk_idx;
      if (out_valid) begin
        if (!active) chk("out_valid_no_op", out_valid, 1'b0);
        else begin
          if (!seen_valid) begin
            chk("latency", cyc - acc_cyc, 12 + stalls);
            chk("rounds_done", step, 11);
            seen_valid = 1;
          end
          if (out_ready) begin
            if (exp_q.size() == 0) chk("scoreboard_nonempty", exp_q.size(), 1);
            else begin
              exp_v = exp_q.pop_front();
              chk("result", out_data, exp_v);
            end
            active = 0;
          end
        end
      end
      hold_prev = out_valid && !out_ready;
      data_prev = out_data;
      if (in_valid && in_ready) begin
        active = 1; seen_valid = 0; acc_cyc = cyc; step = 0; stalls = 0; mode = in_decrypt;
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic wait_idle();
    for (int n = 0; n < 50 && !in_ready; n++) begin
      @(posedge clk); #1;
    end
    chk("idle_reached", in_ready, 1'b1);
  endtask

  task automatic run_op(input logic [127:0] data, input bit dec, input logic [127:0] exp,
                        input bit stall, input int hold, input bit junk);
    int held;
    bit done;
    held = 0; done = 0;
    wait_idle();
    exp_q.push_back(exp);
    stall_en   = stall;
    in_data    = data;
    in_decrypt = dec;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      if (busy && junk) begin
        in_valid   = 1'($urandom_range(0, 1));
        in_data    = {$urandom, $urandom, $urandom, $urandom};
        in_decrypt = 1'($urandom_range(0, 1));
      end else in_valid = 1'b0;
      if (out_valid) begin
        if (held < hold) begin out_ready = 1'b0; held++; end
        else begin out_ready = 1'b1; done = 1; end
      end else out_ready = 1'($urandom_range(0, 1)) & 1'b0;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    stall_en  = 1'b0;
    chk("op_completed", done, 1'b1);
  endtask

  logic [127:0] key, pt, ct, dummy;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    rst_n = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_rk_req", rk_req, 1'b0);
    chk("rst_rk_idx", rk_idx, 4'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    key_exp(C1_KEY);
    run_op(C1_PT, 1'b0, C1_CT, 1'b0, 0, 1'b0);   // known-answer encrypt, minimum latency
    run_op(C1_CT, 1'b1, C1_PT, 1'b0, 0, 1'b0);   // known-answer decrypt, idx 10..0
    run_op(C1_PT, 1'b0, C1_CT, 1'b1, 0, 1'b0);   // key stalls
    run_op(C1_PT, 1'b0, C1_CT, 1'b0, 5, 1'b1);   // result held 5 cycles, in_valid noise

    // Abort during ROUND with counter 5.
    wait_idle();
    exp_q.push_back(C1_CT);
    in_data = C1_PT; in_decrypt = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_rk_idx", rk_idx, 4'd5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_rk_req", rk_req, 1'b0);
    rst_n = 1'b1;
    dummy = exp_q.pop_back();
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      chk("abort_no_out_valid", out_valid, 1'b0);
    end
    run_op(C1_PT, 1'b0, C1_CT, 1'b0, 0, 1'b0);

    for (int n = 0; n < 100; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key_exp(key);
      ct = enc_m(pt);
      dummy = dec_m(ct);
      chk("model_roundtrip", dummy, pt);
      run_op(pt, 1'b0, ct, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      run_op(ct, 1'b1, pt, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
